// File: rtl/cordic_pkg.sv
// Shared definitions for the phase stepper and the CORDIC stage it feeds.
//   - stepper_state_e : phase stepper control states
//   - DEF_*           : default word width, fixed-point shift and frame exponent
//   - full_scale()    : 360 degrees expressed in the fixed-point phase format
//   - frame_len()     : frame length in clocks for a given CORDIC iteration exponent
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_RUN       = 2'd2,
    ST_STOP_PEND = 2'd3
  } stepper_state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_EXPAND_BIT = 16;
  localparam int DEF_CYCLES     = 5;
  localparam int DEG_FULL       = 360;

  // One full turn: 360 * 2^expand_bit.
  function automatic longint unsigned full_scale(input int expand_bit);
    return 64'(DEG_FULL) << expand_bit;
  endfunction

  // Frame length 2^cycles matches the downstream CORDIC iteration count.
  function automatic int frame_len(input int cycles);
    return 1 << cycles;
  endfunction

endpackage

// File: rtl/phase_stepper_if.sv
// Control/data bundle between a phase stepper and its controller.
//   master : drives start, stop, phase_init, step_in, step_load; observes outputs
//   slave  : the phase stepper itself
//
// Signalling: this bundle has no ready path. start, stop and step_load are
// single-cycle strobes sampled on the rising clock edge; phase_init and
// step_in are qualified by start and step_load respectively in that same
// cycle. phase is meaningful only while phase_valid is high, and downstream
// samples it in the cycle frame_start is high. err is sticky until reset.
interface phase_stepper_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  start;
  logic                  stop;
  logic [DATA_WIDTH-1:0] phase_init;
  logic [DATA_WIDTH-1:0] step_in;
  logic                  step_load;
  logic [DATA_WIDTH-1:0] phase;
  logic                  phase_valid;
  logic                  frame_start;
  logic                  err;

  modport master (
    output start, stop, phase_init, step_in, step_load,
    input  phase, phase_valid, frame_start, err
  );

  modport slave (
    input  start, stop, phase_init, step_in, step_load,
    output phase, phase_valid, frame_start, err
  );

endinterface

// File: rtl/phase_stepper.sv
// Phase stepper: presents a fixed-point phase to a CORDIC stage, holding it
// for a whole frame of 2^CYCLES clocks and advancing it by a programmable
// step (mod 360 degrees) at every frame boundary.
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset
//   bus       - phase_stepper_if slave: start/stop/phase_init/step_in/step_load
//               in, phase/phase_valid/frame_start/err out
//   dbg_state - current control state, for observation only
module phase_stepper
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int EXPAND_BIT = DEF_EXPAND_BIT,
  parameter int CYCLES     = DEF_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  phase_stepper_if.slave        bus,
  output stepper_state_e        dbg_state
);

  localparam logic [DATA_WIDTH:0] FULL       = (DATA_WIDTH+1)'(full_scale(EXPAND_BIT));
  localparam logic [CYCLES-1:0]   FRAME_LAST = CYCLES'(frame_len(CYCLES) - 1);

  stepper_state_e          state_q,       state_d;
  logic [CYCLES-1:0]       frame_cnt_q,   frame_cnt_d;
  logic [DATA_WIDTH-1:0]   phase_q,       phase_d;
  logic [DATA_WIDTH-1:0]   next_phase_q,  next_phase_d;
  logic [DATA_WIDTH-1:0]   shadow_step_q, shadow_step_d;
  logic [DATA_WIDTH-1:0]   step_active_q, step_active_d;
  logic                    phase_valid_q, phase_valid_d;
  logic                    err_q,         err_d;

  logic                    boundary;
  logic                    init_ok;
  logic                    step_ok;
  logic [DATA_WIDTH:0]     phase_sum;
  logic [DATA_WIDTH-1:0]   phase_wrapped;

  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q + CYCLES'(1);  // frame is a power of two: wraps naturally
    phase_d       = phase_q;
    next_phase_d  = next_phase_q;
    shadow_step_d = shadow_step_q;
    step_active_d = step_active_q;
    phase_valid_d = phase_valid_q;
    err_d         = err_q;

    boundary = (frame_cnt_q == FRAME_LAST);
    init_ok  = ({1'b0, bus.phase_init} < FULL);
    step_ok  = ({1'b0, bus.step_in}    < FULL);

    if (bus.step_load) begin
      if (step_ok) shadow_step_d = bus.step_in;
      else         err_d         = 1'b1;
    end

    // Taking shadow_step_d (not _q) lets a load coinciding with the boundary
    // edge take effect in that very boundary's update.
    if (boundary) step_active_d = shadow_step_d;

    // Both operands are below FULL, so one conditional subtraction suffices.
    phase_sum     = {1'b0, phase_q} + {1'b0, step_active_d};
    phase_wrapped = (phase_sum >= FULL) ? DATA_WIDTH'(phase_sum - FULL)
                                        : DATA_WIDTH'(phase_sum);

    case (state_q)
      ST_IDLE: begin
        if (!bus.stop && bus.start) begin
          if (init_ok) begin
            next_phase_d = bus.phase_init;
            state_d      = ST_ARMED;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (boundary) begin
          phase_d       = next_phase_q;
          phase_valid_d = 1'b1;
          state_d       = ST_RUN;
        end
      end
      ST_RUN: begin
        if (boundary) phase_d = phase_wrapped;
        if (bus.stop) state_d = ST_STOP_PEND;
      end
      ST_STOP_PEND: begin
        // Phase stays frozen at its last value once stepping ends.
        if (boundary) begin
          phase_valid_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      frame_cnt_q   <= '0;
      phase_q       <= '0;
      next_phase_q  <= '0;
      shadow_step_q <= '0;
      step_active_q <= '0;
      phase_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      phase_q       <= phase_d;
      next_phase_q  <= next_phase_d;
      shadow_step_q <= shadow_step_d;
      step_active_q <= step_active_d;
      phase_valid_q <= phase_valid_d;
      err_q         <= err_d;
    end
  end

  assign bus.phase       = phase_q;
  assign bus.phase_valid = phase_valid_q;
  assign bus.frame_start = (frame_cnt_q == '0);
  assign bus.err         = err_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_phase_stepper.sv
`timescale 1ns/1ps
module tb_phase_stepper;
  import cordic_pkg::*;

  localparam int          DW      = 32;
  localparam logic [31:0] FULL_TB = 32'd23592960;  // 360 * 65536

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phase_stepper_if #(.DATA_WIDTH(DW)) bus ();
  stepper_state_e dbg_state;

  phase_stepper #(
    .DATA_WIDTH(DW),
    .EXPAND_BIT(16),
    .CYCLES(5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Bench-side frame position: starts at 0 with reset, advances every clock.
  logic [4:0] tb_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= '0;
    else     tb_cnt <= tb_cnt + 5'd1;
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] held_phase = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] deg(input int d);
    return 32'(d) << 16;
  endfunction

  // Scoreboard: every frame start with a live phase pops one expected value;
  // inside a frame the phase must not move.
  always @(negedge clk) begin
    if (!rst) begin
      check("frame_start", bus.frame_start, (tb_cnt == 5'd0));
      if (bus.phase_valid) begin
        if (bus.frame_start) begin
          if (exp_q.size() == 0) check("exp_q_nonempty", 0, 1);
          else                   check("phase", bus.phase, exp_q.pop_front());
          check("phase_range", (bus.phase < FULL_TB), 1);
          held_phase = bus.phase;
        end else begin
          check("phase_hold", bus.phase, held_phase);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_cnt(input int n);
    int guard = 0;
    do begin
      tick();
      guard++;
    end while (tb_cnt != 5'(n) && guard < 64);
    if (guard >= 64) check("at_cnt_timeout", guard, 0);
  endtask

  task automatic pulse_start(input logic [31:0] init);
    bus.start = 1'b1; bus.phase_init = init;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic pulse_both(input logic [31:0] init);
    bus.start = 1'b1; bus.stop = 1'b1; bus.phase_init = init;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
  endtask

  task automatic load_step(input logic [31:0] s);
    bus.step_load = 1'b1; bus.step_in = s;
    tick();
    bus.step_load = 1'b0;
  endtask

  task automatic check_stopped(input string tag, input logic [31:0] frozen);
    @(negedge clk);
    check({tag, "_valid"}, bus.phase_valid, 0);
    check({tag, "_phase"}, bus.phase, frozen);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.step_load = 1'b0;
    bus.phase_init = '0; bus.step_in = '0;
    repeat (2) @(negedge clk);
    check("rst_phase", bus.phase, 0);
    check("rst_valid", bus.phase_valid, 0);
    check("rst_err", bus.err, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    #1;
    check("rel_frame_start", bus.frame_start, 1);

    // Basic stepping, 10 degree increment, then stop at frame_cnt 3.
    at_cnt(2); load_step(deg(10));
    exp_q.push_back(deg(0)); exp_q.push_back(deg(10)); exp_q.push_back(deg(20));
    at_cnt(5); pulse_start(deg(0));
    @(negedge clk);
    check("armed_state", dbg_state, ST_ARMED);
    check("armed_valid", bus.phase_valid, 0);
    at_cnt(0); at_cnt(0); at_cnt(0);
    at_cnt(3); pulse_stop();
    @(negedge clk);
    check("stop_pend_state", dbg_state, ST_STOP_PEND);
    check("stop_pend_valid", bus.phase_valid, 1);
    at_cnt(31);
    @(negedge clk);
    check("last_cycle_valid", bus.phase_valid, 1);
    at_cnt(0);  check_stopped("s1_stop", deg(20));
    at_cnt(20); @(negedge clk); check("s1_frozen", bus.phase, deg(20));

    // Wrap through 360: 350 + 20 -> 10 degrees.
    at_cnt(2); load_step(deg(20));
    exp_q.push_back(deg(350)); exp_q.push_back(deg(10)); exp_q.push_back(deg(30));
    at_cnt(5); pulse_start(deg(350));
    at_cnt(0); at_cnt(0); at_cnt(0);
    at_cnt(3); pulse_stop();
    at_cnt(0);  check_stopped("s2_stop", deg(30));

    // Mid-frame step change and a load coinciding with the boundary edge.
    at_cnt(2); load_step(deg(10));
    exp_q.push_back(deg(100)); exp_q.push_back(deg(110)); exp_q.push_back(deg(115));
    exp_q.push_back(deg(120)); exp_q.push_back(deg(121));
    at_cnt(5); pulse_start(deg(100));
    at_cnt(0); at_cnt(0);
    at_cnt(7); load_step(deg(5));
    at_cnt(0); at_cnt(0);
    at_cnt(31); load_step(deg(1));
    at_cnt(3); pulse_stop();
    at_cnt(0);  check_stopped("s3_stop", deg(121));

    // Out-of-range values, stop priority, stop while armed.
    @(negedge clk); check("err_clear", bus.err, 0);
    at_cnt(2); load_step(deg(360));
    @(negedge clk); check("err_step", bus.err, 1);
    at_cnt(5); pulse_start(deg(400));
    @(negedge clk);
    check("bad_init_state", dbg_state, ST_IDLE);
    check("bad_init_err", bus.err, 1);
    pulse_both(deg(0));
    @(negedge clk); check("both_idle_state", dbg_state, ST_IDLE);
    pulse_start(deg(0));
    @(negedge clk); check("arm_again_state", dbg_state, ST_ARMED);
    pulse_stop();
    @(negedge clk); check("armed_stop_state", dbg_state, ST_IDLE);
    // Rejected 360 must have left the 1 degree step in place.
    exp_q.push_back(deg(0)); exp_q.push_back(deg(1));
    at_cnt(5); pulse_start(deg(0));
    at_cnt(0); at_cnt(0);
    at_cnt(3); pulse_both(deg(0));
    @(negedge clk); check("both_run_state", dbg_state, ST_STOP_PEND);
    at_cnt(0);  check_stopped("s4_stop", deg(1));
    check("err_sticky", bus.err, 1);

    // Asynchronous reset in the middle of a running frame.
    exp_q.push_back(deg(45));
    at_cnt(5); pulse_start(deg(45));
    at_cnt(0);
    at_cnt(15);
    #2 rst = 1'b1;
    #1;
    check("arst_phase", bus.phase, 0);
    check("arst_valid", bus.phase_valid, 0);
    check("arst_err", bus.err, 0);
    check("arst_state", dbg_state, ST_IDLE);
    check("arst_frame_start", bus.frame_start, 1);
    @(negedge clk); rst = 1'b0;
    #1 check("arel_frame_start", bus.frame_start, 1);
    // Step registers were cleared: phase must stay at the start value.
    exp_q.push_back(deg(7)); exp_q.push_back(deg(7));
    at_cnt(5); pulse_start(deg(7));
    at_cnt(0); at_cnt(0);
    at_cnt(3); pulse_stop();
    at_cnt(0);  check_stopped("s5_stop", deg(7));

    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_stepper.md
PHASE_STEPPER -- requirements
Module: phase_stepper

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the phase/step word width.
REQ-002 SHALL have parameter EXPAND_BIT, default 16, giving the fixed-point left-shift: degrees times 2^EXPAND_BIT.
REQ-003 SHALL have parameter CYCLES, default 5, setting frame length FRAME = 2^CYCLES clocks, which matches downstream CORDIC iteration count.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1, the reset; it is asynchronous and active-high.
REQ-006 SHALL have port start, input, 1, a one-cycle request to begin stepping from phase_init.
REQ-007 SHALL have port stop, input, 1, a one-cycle request to end stepping at the next frame boundary.
REQ-008 SHALL have port phase_init, input, DATA_WIDTH, the unsigned start phase, captured on accepted start.
REQ-009 SHALL have port step_in, input, DATA_WIDTH, the unsigned phase increment per frame.
REQ-010 SHALL have port step_load, input, 1, a one-cycle strobe that writes step_in to the shadow step register.
REQ-011 SHALL have port phase, output, DATA_WIDTH, the phase presented downstream, held constant for a whole frame.
REQ-012 SHALL have port phase_valid, output, 1, high while phase is a live stepped value.
REQ-013 SHALL have port frame_start, output, 1, high during frame_cnt==0, the cycle in which downstream samples phase.
REQ-014 SHALL have port err, output, 1, a sticky flag for a rejected out-of-range phase_init or step_in.

Function
REQ-015 SHALL define FULL = 360*2^EXPAND_BIT; legal phase and step values are 0..FULL-1.
REQ-016 SHALL run frame_cnt (CYCLES bits) freely from 0 after reset, wrapping FRAME-1 -> 0 in every state.
REQ-017 SHALL implement states IDLE, ARMED, RUN and STOP_PEND.
REQ-018 SHALL move IDLE -> ARMED on start with phase_init < FULL, loading phase_init into the next-phase register; if phase_init >= FULL, start SHALL be ignored and err SHALL set.
REQ-019 SHALL move ARMED -> RUN on the edge where frame_cnt goes FRAME-1 -> 0; phase SHALL take the next-phase value and phase_valid SHALL rise on that edge.
REQ-020 SHALL, in RUN, update on each FRAME-1 -> 0 edge as phase <= (phase + step_active) mod FULL, computed in DATA_WIDTH+1 bits, subtracting FULL once when sum >= FULL.
REQ-021 SHALL hold phase unchanged on every other edge, so phase is stable across all FRAME cycles.
REQ-022 SHALL store step_in in shadow_step when step_load is high and step_in < FULL; step_in >= FULL SHALL be discarded and err SHALL set.
REQ-023 SHALL copy shadow_step to step_active only on a FRAME-1 -> 0 edge, so a step change never alters the current frame's phase.
REQ-024 SHALL, when step_load and the boundary edge coincide, use the new step_in value for that boundary's update.
REQ-025 SHALL move RUN -> STOP_PEND on stop; on the next FRAME-1 -> 0 edge it SHALL go to IDLE with phase_valid low and phase held at its last value.
REQ-026 SHALL treat start while ARMED, RUN or STOP_PEND as ignored; stop while IDLE or ARMED SHALL return to IDLE immediately.
REQ-027 SHALL give stop priority over start when both are asserted in the same cycle.
REQ-028 SHALL clear err only by reset.

Reset
REQ-029 SHALL, on rst, asynchronously set frame_cnt=0, state=IDLE, phase=0, shadow_step=0, step_active=0, phase_valid=0 and err=0.
REQ-030 SHALL, after rst, make frame_start high in the first cycle after reset release (frame_cnt==0).
REQ-031 SHALL, if rst is asserted mid-frame or mid-RUN, abort immediately with no completion of the pending update.

Structure
REQ-032 SHALL place the state enum, FULL, and the FRAME/width helper constants in a shared package (cordic_pkg), also used by the CORDIC stage.
REQ-033 SHALL be a single module with no sub-modules; the modulo adder is inline logic.

Verification
REQ-034 Scenario: start with phase_init=0, step 10 deg (655360) -> phase 0, 655360, 1310720 on successive frame starts, each held for 32 cycles.
REQ-035 Scenario: phase_init=350 deg, step 20 deg -> next phase = 10 deg (655360), with no value >= FULL ever output.
REQ-036 Scenario: step_load 5 deg at frame_cnt=7 -> the current frame is unchanged and the increment after the next boundary is 5 deg.
REQ-037 Scenario: step_in=360 deg or phase_init=400 deg -> err=1, step/state unchanged, err held until rst.
REQ-038 Scenario: stop at frame_cnt=3 in RUN -> phase_valid drops at the next 31 -> 0 edge, phase frozen; start and stop together -> stop wins.
REQ-039 Scenario: rst pulse at frame_cnt=15 during RUN -> all outputs 0 asynchronously, frame_start at the first cycle after release.
